// File: rtl/demultiplexer_5ch.sv
// rtl/demultiplexer_5ch.sv - registered 1-to-5 bus demultiplexer with update pulse, load counter and select-error flag
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   data_in    bus word to distribute
//   sel        destination select (0..4 = a..e, 5..7 illegal)
//   load       write strobe
//   clear_err  synchronous clear of sel_err
//   out_a..e   destination holding registers
//   upd        one-hot pulse naming the destination written on the previous edge
//   load_cnt   count of accepted loads, wraps modulo 2^CNT_WIDTH
//   sel_err    sticky illegal-select flag
//
// Build option: define DEMUX5_SEL_ERR_EN to enable sel_err/clear_err; when
// undefined, sel_err is held at 0 and illegal loads are silently dropped.
module demultiplexer_5ch #(
  parameter int WORD_SIZE = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic [2:0]           sel,
  input  logic                 load,
  input  logic                 clear_err,
  output logic [WORD_SIZE-1:0] out_a,
  output logic [WORD_SIZE-1:0] out_b,
  output logic [WORD_SIZE-1:0] out_c,
  output logic [WORD_SIZE-1:0] out_d,
  output logic [WORD_SIZE-1:0] out_e,
  output logic [4:0]           upd,
  output logic [CNT_WIDTH-1:0] load_cnt,
  output logic                 sel_err
);

  logic [4:0][WORD_SIZE-1:0] out_q;
  logic [4:0]                upd_q, upd_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      sel_legal;
  logic                      load_illegal;

  assign sel_legal    = (sel <= 3'd4);
  assign load_illegal = load && !sel_legal;

  // The one-hot write decode doubles as the next upd value, so the pulse
  // always names exactly the register that took data on this edge.
  always_comb begin
    upd_d = 5'b00000;
    cnt_d = cnt_q;
    if (load && sel_legal) begin
      upd_d = 5'b00001 << sel;
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef DEMUX5_SEL_ERR_EN
  // Set has priority over clear when both occur on the same edge.
  always_comb begin
    err_d = err_q;
    if (load_illegal) begin
      err_d = 1'b1;
    end else if (clear_err) begin
      err_d = 1'b0;
    end
  end
`else
  logic unused_err_inputs;
  assign unused_err_inputs = clear_err ^ load_illegal;

  always_comb begin
    err_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      upd_q <= 5'b00000;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (upd_d[i]) begin
          out_q[i] <= data_in;
        end
      end
      upd_q <= upd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign out_a    = out_q[0];
  assign out_b    = out_q[1];
  assign out_c    = out_q[2];
  assign out_d    = out_q[3];
  assign out_e    = out_q[4];
  assign upd      = upd_q;
  assign load_cnt = cnt_q;
  assign sel_err  = err_q;

endmodule

// File: tb/tb_demultiplexer_5ch.sv
// tb/tb_demultiplexer_5ch.sv - self-checking bench for demultiplexer_5ch against a behavioural model
module tb_demultiplexer_5ch;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [2:0]    sel = '0;
  logic          load = 1'b0;
  logic          clear_err = 1'b0;
  logic [W-1:0]  out_a, out_b, out_c, out_d, out_e;
  logic [4:0]    upd;
  logic [CW-1:0] load_cnt;
  logic          sel_err;

  demultiplexer_5ch #(.WORD_SIZE(W), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .sel       (sel),
    .load      (load),
    .clear_err (clear_err),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_e     (out_e),
    .upd       (upd),
    .load_cnt  (load_cnt),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: five destinations, last update, accepted-load count, error flag.
  int m_reg [5];
  int m_upd;
  int m_cnt;
  int m_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check_eq({ctx, "/out_a"},    32'(out_a),    32'(m_reg[0]));
    check_eq({ctx, "/out_b"},    32'(out_b),    32'(m_reg[1]));
    check_eq({ctx, "/out_c"},    32'(out_c),    32'(m_reg[2]));
    check_eq({ctx, "/out_d"},    32'(out_d),    32'(m_reg[3]));
    check_eq({ctx, "/out_e"},    32'(out_e),    32'(m_reg[4]));
    check_eq({ctx, "/upd"},      32'(upd),      32'(m_upd));
    check_eq({ctx, "/load_cnt"}, 32'(load_cnt), 32'(m_cnt));
    check_eq({ctx, "/sel_err"},  32'(sel_err),  32'(m_err));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = 0;
    m_upd = 0;
    m_cnt = 0;
    m_err = 0;
  endtask

  // Drives one set of inputs, lets one rising edge pass, updates the model
  // from the rules, and compares every output just after the edge.
  task automatic cycle(input string ctx, input int d, input int s, input bit l, input bit c);
    data_in   = W'(d);
    sel       = 3'(s);
    load      = l;
    clear_err = c;
    @(posedge clk);
    #1;
    if (l && s < 5) begin
      m_reg[s] = d;
      m_upd    = 1 << s;
      m_cnt    = (m_cnt + 1) % (1 << CW);
    end else begin
      m_upd = 0;
    end
`ifdef DEMUX5_SEL_ERR_EN
    if (l && s >= 5) m_err = 1;
    else if (c) m_err = 0;
`endif
    check_all(ctx);
  endtask

  // Asserts reset between edges so the clear must appear without a clock.
  task automatic apply_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    rst = 1'b1;

    cycle("pre_c", 'hCC, 2, 1'b1, 1'b0);
    apply_reset();

    cycle("sweep_a", 'hAA, 0, 1'b1, 1'b0);
    cycle("sweep_b", 'hBB, 1, 1'b1, 1'b0);
    cycle("sweep_c", 'hCC, 2, 1'b1, 1'b0);
    cycle("sweep_d", 'hDD, 3, 1'b1, 1'b0);
    cycle("sweep_e", 'hEE, 4, 1'b1, 1'b0);
    check_eq("sweep_cnt", 32'(load_cnt), 32'd5);

    cycle("ill_5", 'hFF, 5, 1'b1, 1'b0);
    cycle("ill_6", 'hFF, 6, 1'b1, 1'b0);
    cycle("ill_7", 'hFF, 7, 1'b1, 1'b0);
    cycle("ill_set_wins", 'hFF, 7, 1'b1, 1'b1);
    cycle("ill_clear", 'hFF, 7, 1'b0, 1'b1);

    cycle("hold_55", 'h55, 1, 1'b0, 1'b0);
    cycle("hold_aa", 'hAA, 3, 1'b0, 1'b0);
    cycle("hold_00", 'h00, 6, 1'b0, 1'b0);
    cycle("hold_ff", 'hFF, 0, 1'b0, 1'b0);
    cycle("tog_b0", 'h00, 1, 1'b1, 1'b0);
    cycle("tog_b1", 'hFF, 1, 1'b1, 1'b0);
    cycle("tog_end", 'h00, 1, 1'b0, 1'b0);

    apply_reset();
    for (int i = 0; i < 256; i++) begin
      cycle("wrap", int'($urandom_range(0, 255)), int'($urandom_range(0, 4)), 1'b1, 1'b0);
    end
    check_eq("wrap_zero", 32'(load_cnt), 32'd0);
    cycle("wrap_257", 'h3C, 2, 1'b1, 1'b0);
    check_eq("wrap_one", 32'(load_cnt), 32'd1);

    for (int i = 0; i < 400; i++) begin
      cycle("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
      if (i == 200) apply_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
